// File: rtl/conf_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : conf_loader_if
// Description : Byte input and configuration/status output bundle of conf_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface conf_loader_if #(
  parameter int CH_NO = 4
);
  logic [7:0]          i_data;
  logic                i_avail;
  logic [CH_NO*80-1:0] o_conf;
  logic                o_ack;
  logic                o_err;
  logic [7:0]          o_ch;
  logic                o_busy;

  modport master (
    output i_data, i_avail,
    input  o_conf, o_ack, o_err, o_ch, o_busy
  );

  modport slave (
    input  i_data, i_avail,
    output o_conf, o_ack, o_err, o_ch, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/conf_loader.sv
`default_nettype none
// ============================================================================
// Module      : conf_loader
// Description : UART frame decoder committing checksummed 80-bit channel configs.
// Revision    : 1.0 - initial release
// ============================================================================
module conf_loader #(
  parameter int         CH_NO   = 4,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 50000
) (
  input  wire logic     i_clk,
  input  wire logic     _rst,
  conf_loader_if.slave  bus
);
  localparam int               c_tmo_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHAN    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_avail_d;
  logic [7:0]          r_ch_lat;
  logic [7:0]          r_csum;
  logic [3:0]          r_k;
  logic [79:0]         r_shadow;
  logic [c_tmo_w-1:0]  r_tcnt;
  logic [CH_NO*80-1:0] r_conf;
  logic                r_ack;
  logic                r_err;
  logic [7:0]          r_ch_out;

  logic w_accept;
  logic w_timeout;
  logic w_good;

  assign w_accept  = bus.i_avail & ~r_avail_d;
  // A byte arriving on the expiry cycle takes priority over the abort.
  assign w_timeout = (r_state != S_IDLE) && !w_accept && (r_tcnt == c_tmo_max);
  assign w_good    = (bus.i_data == r_csum) && ({1'b0, r_ch_lat} < 9'(CH_NO));

  always_ff @(posedge i_clk) begin
    if (!_rst) begin
      r_state   <= S_IDLE;
      r_avail_d <= 1'b0;
      r_ch_lat  <= '0;
      r_csum    <= '0;
      r_k       <= '0;
      r_shadow  <= '0;
      r_tcnt    <= '0;
      r_conf    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_ch_out  <= '0;
    end else begin
      r_avail_d <= bus.i_avail;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;

      if (w_accept || r_state == S_IDLE) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + c_tmo_w'(1);
      end

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_tcnt  <= '0;
      end else if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_data == HEADER) begin
              r_state <= S_CHAN;
            end
          end
          S_CHAN: begin
            r_ch_lat <= bus.i_data;
            r_csum   <= bus.i_data;
            r_k      <= '0;
            r_state  <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            for (int b = 0; b < 10; b++) begin
              if (r_k == 4'(b)) begin
                r_shadow[b*8 +: 8] <= bus.i_data;
              end
            end
            r_csum <= r_csum ^ bus.i_data;
            r_k    <= r_k + 4'd1;
            if (r_k == 4'd9) begin
              r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            r_ch_out <= r_ch_lat;
            if (w_good) begin
              for (int c = 0; c < CH_NO; c++) begin
                if (r_ch_lat == c[7:0]) begin
                  r_conf[c*80 +: 80] <= r_shadow;
                end
              end
              r_ack <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_conf = r_conf;
  assign bus.o_ack  = r_ack;
  assign bus.o_err  = r_err;
  assign bus.o_ch   = r_ch_out;
  assign bus.o_busy = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_conf_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_conf_loader
// Description : Self-checking directed bench for conf_loader frame decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conf_loader;
  localparam int         c_ch_no = 4;
  localparam int         c_tmo   = 40;
  localparam logic [7:0] c_hdr   = 8'hA5;

  localparam logic [79:0] c_s1  = 80'hAA99_8877_6655_4433_2211;
  localparam logic [79:0] c_s0  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] c_s2  = 80'h0000_8040_2010_0804_0201;
  localparam logic [79:0] c_s3  = 80'h0807_0605_0403_0201_00A5;
  localparam logic [79:0] c_s1b = 80'h5A00_0000_0000_0000_0000;
  localparam logic [79:0] c_z   = 80'h0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conf_loader_if #(.CH_NO(c_ch_no)) bus ();

  conf_loader #(
    .CH_NO  (c_ch_no),
    .HEADER (c_hdr),
    .TIMEOUT(c_tmo)
  ) dut (
    .i_clk(clk),
    ._rst (rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0]   ch;
    logic [79:0]  pay;
    logic [7:0]   cs;
    logic         ack;
    logic [319:0] conf;
  } vec_t;

  vec_t tbl[8];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_ack  = 0;
  int   n_errp = 0;
  int   n_both = 0;

  always @(negedge clk) begin
    if (bus.o_ack) n_ack++;
    if (bus.o_err) n_errp++;
    if (bus.o_ack && bus.o_err) n_both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_data  = b;
    bus.i_avail = 1'b1;
    @(posedge clk); #1;
    bus.i_avail = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sends CS and checks the single-cycle result window that follows it.
  task automatic close_frame(input logic [7:0] cs, input logic exp_ack,
                             input logic [7:0] exp_ch, input logic [319:0] exp_conf);
    bus.i_data  = cs;
    bus.i_avail = 1'b1;
    @(posedge clk); #1;
    chk("ack_pulse", bus.o_ack, exp_ack);
    chk("err_pulse", bus.o_err, !exp_ack);
    chk("ch_out", bus.o_ch, exp_ch);
    chk("conf_after_cs", bus.o_conf, exp_conf);
    chk("busy_after_cs", bus.o_busy, 1'b0);
    bus.i_avail = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", bus.o_ack, 1'b0);
    chk("err_one_cycle", bus.o_err, 1'b0);
  endtask

  task automatic frame(input logic [7:0] ch, input logic [79:0] pay, input logic [7:0] cs,
                       input logic exp_ack, input logic [319:0] prev_conf,
                       input logic [319:0] exp_conf);
    send_byte(c_hdr);
    chk("busy_in_frame", bus.o_busy, 1'b1);
    send_byte(ch);
    for (int i = 0; i < 10; i++) send_byte(pay[i*8 +: 8]);
    chk("conf_hold_partial", bus.o_conf, prev_conf);
    close_frame(cs, exp_ack, ch, exp_conf);
  endtask

  initial begin
    logic [319:0] conf_exp;
    int           a0;
    int           e0;

    tbl[0] = '{8'h01, c_s1,  8'hBA, 1'b1, {c_z,  c_z,  c_s1,  c_z }};
    tbl[1] = '{8'h01, c_s1,  8'h00, 1'b0, {c_z,  c_z,  c_s1,  c_z }};
    tbl[2] = '{8'h04, c_s1,  8'hBF, 1'b0, {c_z,  c_z,  c_s1,  c_z }};
    tbl[3] = '{8'hFF, c_s1,  8'h44, 1'b0, {c_z,  c_z,  c_s1,  c_z }};
    tbl[4] = '{8'h84, c_s0,  8'h84, 1'b0, {c_z,  c_z,  c_s1,  c_z }};
    tbl[5] = '{8'h00, c_s0,  8'h00, 1'b1, {c_z,  c_z,  c_s1,  c_s0}};
    tbl[6] = '{8'h02, c_s2,  8'hFD, 1'b1, {c_z,  c_s2, c_s1,  c_s0}};
    tbl[7] = '{8'h01, c_s1b, 8'h5B, 1'b1, {c_z,  c_s2, c_s1b, c_s0}};

    rst_n       = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_avail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_conf", bus.o_conf, '0);
    chk("rst_ack", bus.o_ack, 1'b0);
    chk("rst_err", bus.o_err, 1'b0);
    chk("rst_ch", bus.o_ch, 8'h00);
    chk("rst_busy", bus.o_busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    conf_exp = '0;
    for (int v = 0; v < 8; v++) begin
      frame(tbl[v].ch, tbl[v].pay, tbl[v].cs, tbl[v].ack, conf_exp, tbl[v].conf);
      conf_exp = tbl[v].conf;
    end

    // Leading junk ignored, then channel 3 with a header-valued payload byte.
    a0 = n_ack;
    e0 = n_errp;
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("junk_busy", bus.o_busy, 1'b0);
    chk("junk_no_pulse", n_ack + n_errp, a0 + e0);
    frame(8'h03, c_s3, 8'hAE, 1'b1, conf_exp, {c_s3, c_s2, c_s1b, c_s0});
    conf_exp = {c_s3, c_s2, c_s1b, c_s0};

    // Timeout: abort on the cycle the idle count reaches the limit.
    send_byte(c_hdr);
    send_byte(8'h02);
    bus.i_data  = 8'h10;
    bus.i_avail = 1'b1;
    @(posedge clk); #1;
    bus.i_avail = 1'b0;
    repeat (c_tmo) @(posedge clk);
    #1;
    chk("tmo_not_yet_err", bus.o_err, 1'b0);
    chk("tmo_not_yet_busy", bus.o_busy, 1'b1);
    @(posedge clk); #1;
    chk("tmo_err", bus.o_err, 1'b1);
    chk("tmo_busy", bus.o_busy, 1'b0);
    chk("tmo_ch_kept", bus.o_ch, 8'h03);
    chk("tmo_conf_kept", bus.o_conf, conf_exp);
    @(posedge clk); #1;
    chk("tmo_err_one_cycle", bus.o_err, 1'b0);
    frame(8'h02, c_s1, 8'hB9, 1'b1, conf_exp, {c_s3, c_s1, c_s1b, c_s0});

    // Reset beats a simultaneous header accept.
    rst_n       = 1'b0;
    bus.i_data  = c_hdr;
    bus.i_avail = 1'b1;
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.i_avail = 1'b0;
    chk("rst_accept_busy", bus.o_busy, 1'b0);
    chk("rst_accept_conf", bus.o_conf, '0);
    @(posedge clk); #1;
    chk("rst_accept_busy2", bus.o_busy, 1'b0);

    // Reset mid-frame after P4, then the rest of the frame is ignored.
    a0 = n_ack;
    e0 = n_errp;
    send_byte(c_hdr);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'hFF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", bus.o_busy, 1'b0);
    chk("midrst_conf", bus.o_conf, '0);
    for (int i = 0; i < 5; i++) send_byte(8'hFF);
    send_byte(8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_pulse", n_ack + n_errp, a0 + e0);
    chk("midrst_conf_end", bus.o_conf, '0);
    chk("midrst_busy_end", bus.o_busy, 1'b0);
    chk("ack_err_exclusive", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
